// File: rtl/fmint_tile_reader.sv
// fmint_tile_reader: walks a rows x cols sub-tile of the FMINT RAM and streams pixels over valid/ready
module fmint_tile_reader #(
    parameter int PX_W = 16,
    parameter int FMINT_N_ELEM = 4096,
    parameter int DIM_W = 8,
    localparam int AW = $clog2(FMINT_N_ELEM)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   cfg_base,
    input  logic [DIM_W-1:0] cfg_rows,
    input  logic [DIM_W-1:0] cfg_cols,
    input  logic [AW-1:0]   cfg_stride,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_write,
    output logic [PX_W-1:0] ram_data,
    input  logic [PX_W-1:0] ram_res,
    output logic [PX_W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_eol,
    output logic            out_last,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, row_base_q, row_base_d, stride_q, stride_d;
    logic [DIM_W-1:0] r_q, r_d, c_q, c_d, rows_q, rows_d, cols_q, cols_d;
    logic a_v_q, a_v_d, r_v_q, r_v_d, r_eol_q, r_eol_d, r_last_q, r_last_d;
    logic [PX_W+1:0] fifo_q [2];
    logic [PX_W+1:0] fifo_d [2];
    logic wr_q, wr_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;
    logic [1:0] cnt_q, cnt_d, cnt_nx;
    logic pop, commit, a_eol, a_last;

    // The element held in ram_addr is re-read every cycle; it is committed (its data captured
    // next edge) only when the FIFO is sure to have room then, so stalls never lose data.
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        row_base_d = row_base_q;
        stride_d = stride_q;
        r_d = r_q;
        c_d = c_q;
        rows_d = rows_q;
        cols_d = cols_q;
        a_v_d = a_v_q;
        fifo_d = fifo_q;
        wr_d = wr_q;
        rd_d = rd_q;
        pop = (cnt_q != 2'd0) && out_ready;
        cnt_nx = cnt_q + {1'b0, r_v_q} - {1'b0, pop};
        a_eol = c_q == cols_q - 1'b1;
        a_last = a_eol && (r_q == rows_q - 1'b1);
        commit = a_v_q && (cnt_nx < 2'd2);
        cnt_d = cnt_nx;
        r_v_d = commit;
        r_eol_d = commit ? a_eol : r_eol_q;
        r_last_d = commit ? a_last : r_last_q;
        if (r_v_q) begin
            fifo_d[wr_q] = {r_last_q, r_eol_q, ram_res};
            wr_d = ~wr_q;
        end
        if (pop)
            rd_d = ~rd_q;
        if (commit) begin
            if (a_last)
                a_v_d = 1'b0;
            else if (a_eol) begin
                r_d = r_q + 1'b1;
                c_d = '0;
                row_base_d = row_base_q + stride_q;
                addr_d = row_base_q + stride_q;
            end else begin
                c_d = c_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end
        end
        case (state_q)
            IDLE: if (start) begin
                if (cfg_rows == '0 || cfg_cols == '0)
                    state_d = DONE;
                else begin
                    state_d = ISSUE;
                    rows_d = cfg_rows;
                    cols_d = cfg_cols;
                    stride_d = cfg_stride;
                    addr_d = cfg_base;
                    row_base_d = cfg_base;
                    r_d = '0;
                    c_d = '0;
                    a_v_d = 1'b1;
                end
            end
            ISSUE: state_d = (commit && a_last) ? DRAIN : ISSUE;
            DRAIN: state_d = (cnt_nx == 2'd0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = state_d == DONE;
    end

    // State, address generator, read pipeline and output FIFO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q <= '0;
            row_base_q <= '0;
            stride_q <= '0;
            r_q <= '0;
            c_q <= '0;
            rows_q <= '0;
            cols_q <= '0;
            a_v_q <= 1'b0;
            r_v_q <= 1'b0;
            r_eol_q <= 1'b0;
            r_last_q <= 1'b0;
            fifo_q <= '{default: '0};
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            row_base_q <= row_base_d;
            stride_q <= stride_d;
            r_q <= r_d;
            c_q <= c_d;
            rows_q <= rows_d;
            cols_q <= cols_d;
            a_v_q <= a_v_d;
            r_v_q <= r_v_d;
            r_eol_q <= r_eol_d;
            r_last_q <= r_last_d;
            fifo_q <= fifo_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign ram_addr = addr_q;
    assign ram_write = 1'b0;
    assign ram_data = '0;
    assign {out_last, out_eol, out_data} = fifo_q[rd_q];
    assign out_valid = cnt_q != 2'd0;
    assign busy = busy_q;
    assign done = done_q;
endmodule
